// File: rtl/wb_pipe_stage.sv
// ---------------------------------------------------------------------------
// wb_pipe_stage
//
// Writeback pipeline register for a multi-lane issue bundle. The stage has two
// slots: "main" drives the writeback outputs, and "skid" catches one extra
// bundle when writeback stalls. Because of the skid slot, in_ready can come
// straight from a flop without losing throughput.
//
// While a bundle is captured, the lane write-enables are cleaned up:
//   - a lane that writes register 0 has its write-enable dropped
//   - if several lanes write the same register, only the highest lane keeps
//     its enable, because the highest lane is the youngest in program order
//
// Parameters
//   LANES : issue lanes per bundle (1..4)
//   XLEN  : result width per lane
//   RW    : destination register index width
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous, active-high reset
//   flush     : synchronous kill of held and incoming bundles
//   in_valid  : upstream bundle present
//   in_ready  : stage can accept a bundle this cycle (registered)
//   in_we     : per-lane write-enable
//   in_rd     : per-lane destination index, lane k at [k*RW +: RW]
//   in_res    : per-lane result, lane k at [k*XLEN +: XLEN]
//   out_valid : bundle presented to writeback
//   out_ready : writeback consumes the presented bundle
//   out_we    : presented write-enables, zero whenever out_valid is low
//   out_rd    : presented destination indices
//   out_res   : presented results
// ---------------------------------------------------------------------------
module wb_pipe_stage #(
    parameter int LANES = 2,
    parameter int XLEN  = 32,
    parameter int RW    = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES-1:0]      in_we,
    input  logic [LANES*RW-1:0]   in_rd,
    input  logic [LANES*XLEN-1:0] in_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      out_we,
    output logic [LANES*RW-1:0]   out_rd,
    output logic [LANES*XLEN-1:0] out_res
);

    logic                  main_valid;
    logic [LANES-1:0]      main_we;
    logic [LANES*RW-1:0]   main_rd;
    logic [LANES*XLEN-1:0] main_res;

    logic                  skid_valid;
    logic [LANES-1:0]      skid_we;
    logic [LANES*RW-1:0]   skid_rd;
    logic [LANES*XLEN-1:0] skid_res;

    logic                  in_ready_q;

    logic [LANES-1:0]      cap_we;
    logic                  accept;
    logic                  main_valid_n;
    logic                  skid_valid_n;
    logic                  load_main_from_in;
    logic                  load_main_from_skid;
    logic                  load_skid;

    // Clean up the incoming write-enables before either slot captures them.
    // A lane loses its enable if it targets register 0. It also loses its
    // enable if any higher lane with an active enable targets the same
    // register. A lane that is masked only for writing r0 does not matter
    // here, because a higher lane writing r0 is already dead on its own.
    always_comb begin
        cap_we = '0;
        for (int i = 0; i < LANES; i++) begin
            cap_we[i] = in_we[i] && (in_rd[i*RW +: RW] != '0);
            for (int j = i + 1; j < LANES; j++) begin
                if (in_we[j] && (in_rd[j*RW +: RW] == in_rd[i*RW +: RW])) begin
                    cap_we[i] = 1'b0;
                end
            end
        end
    end

    assign accept = in_valid && in_ready_q && !flush;

    // Slot bookkeeping. First, if writeback takes the main bundle, main is
    // refilled from skid when skid is occupied. Otherwise main is refilled
    // from the input. A bundle never goes around an older one waiting in
    // skid, and this keeps the bundles in order. Second, an empty main takes
    // the input directly. Skid is only used when main is stalled. Flush
    // overrides everything and empties both slots.
    always_comb begin
        main_valid_n        = main_valid;
        skid_valid_n        = skid_valid;
        load_main_from_in   = 1'b0;
        load_main_from_skid = 1'b0;
        load_skid           = 1'b0;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (main_valid && out_ready) begin
            if (skid_valid) begin
                load_main_from_skid = 1'b1;
                skid_valid_n        = 1'b0;
            end else if (accept) begin
                load_main_from_in = 1'b1;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (!main_valid) begin
            if (accept) begin
                load_main_from_in = 1'b1;
                main_valid_n      = 1'b1;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_n = 1'b1;
        end
    end

    // State registers. in_ready gets its own flop, loaded with the inverse
    // of the next skid valid. It therefore depends on nothing combinational
    // from the current cycle's handshake inputs. Data fields are not cleared
    // on flush, because their valid bits already say they are dead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_we    <= '0;
            main_rd    <= '0;
            main_res   <= '0;
            skid_valid <= 1'b0;
            skid_we    <= '0;
            skid_rd    <= '0;
            skid_res   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            in_ready_q <= !skid_valid_n;
            if (load_main_from_skid) begin
                main_we  <= skid_we;
                main_rd  <= skid_rd;
                main_res <= skid_res;
            end else if (load_main_from_in) begin
                main_we  <= cap_we;
                main_rd  <= in_rd;
                main_res <= in_res;
            end
            if (load_skid) begin
                skid_we  <= cap_we;
                skid_rd  <= in_rd;
                skid_res <= in_res;
            end
        end
    end

    // All outputs come from registers. The write-enables are gated by the
    // valid bit, so a stale bundle left in main can never cause a write.
    assign in_ready  = in_ready_q;
    assign out_valid = main_valid;
    assign out_we    = main_we & {LANES{main_valid}};
    assign out_rd    = main_rd;
    assign out_res   = main_res;

endmodule

// File: tb/tb_wb_pipe_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_pipe_stage
//
// Directed bench for wb_pipe_stage. The main instance uses the default
// 2-lane, 32-bit configuration. A second instance is built with 4 lanes and
// 64-bit results, to cover the four-lane write-enable cleanup. Inputs change
// 1 time unit after a rising edge, and outputs are sampled at that same
// point, away from the edge.
// ---------------------------------------------------------------------------
module tb_wb_pipe_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_we;
    logic [9:0]  in_rd;
    logic [63:0] in_res;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_we;
    logic [9:0]  out_rd;
    logic [63:0] out_res;

    logic         flush4;
    logic         in_valid4;
    logic         in_ready4;
    logic [3:0]   in_we4;
    logic [19:0]  in_rd4;
    logic [255:0] in_res4;
    logic         out_valid4;
    logic         out_ready4;
    logic [3:0]   out_we4;
    logic [19:0]  out_rd4;
    logic [255:0] out_res4;

    int check_count;
    int error_count;

    wb_pipe_stage #(.LANES(2), .XLEN(32), .RW(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_we     (in_we),
        .in_rd     (in_rd),
        .in_res    (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_we    (out_we),
        .out_rd    (out_rd),
        .out_res   (out_res)
    );

    wb_pipe_stage #(.LANES(4), .XLEN(64), .RW(5)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_we     (in_we4),
        .in_rd     (in_rd4),
        .in_res    (in_res4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_we    (out_we4),
        .out_rd    (out_rd4),
        .out_res   (out_res4)
    );

    // 10-unit clock with rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backstop in case the sequence below ever stops advancing.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [255:0] actual,
                               input logic [255:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", tag, actual, expected);
        end
    endtask

    // Drive one beat on the 2-lane instance.
    task automatic applyStimulus(input logic v, input logic [1:0] we,
                                 input logic [9:0] rd, input logic [63:0] res,
                                 input logic ordy, input logic fl);
        in_valid  = v;
        in_we     = we;
        in_rd     = rd;
        in_res    = res;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [63:0] RES_A = {32'd101, 32'd100};
    localparam logic [63:0] RES_B = {32'd201, 32'd200};
    localparam logic [63:0] RES_C = {32'd301, 32'd300};
    localparam logic [63:0] RES_D = {32'd401, 32'd400};
    localparam logic [9:0]  RD_A  = {5'd1, 5'd2};
    localparam logic [9:0]  RD_B  = {5'd3, 5'd4};
    localparam logic [9:0]  RD_C  = {5'd5, 5'd6};
    localparam logic [9:0]  RD_D  = {5'd7, 5'd8};

    initial begin
        check_count = 0;
        error_count = 0;
        reset       = 1'b1;
        applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, 1'b0, 1'b0);
        flush4     = 1'b0;
        in_valid4  = 1'b0;
        in_we4     = '0;
        in_rd4     = '0;
        in_res4    = '0;
        out_ready4 = 1'b1;

        // Values held during reset
        #12;
        checkOutput("rst_out_valid", 256'(out_valid), 256'd0);
        checkOutput("rst_out_we", 256'(out_we), 256'd0);
        checkOutput("rst_out_rd", 256'(out_rd), 256'd0);
        checkOutput("rst_out_res", 256'(out_res), 256'd0);
        checkOutput("rst_in_ready", 256'(in_ready), 256'd1);
        checkOutput("rst4_out_we", 256'(out_we4), 256'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Single bundle passes through with one cycle of latency
        applyStimulus(1'b1, 2'b11, {5'd7, 5'd3}, {32'hB, 32'hA}, 1'b1, 1'b0);
        tick();
        checkOutput("basic_valid", 256'(out_valid), 256'd1);
        checkOutput("basic_rd", 256'(out_rd), 256'({5'd7, 5'd3}));
        checkOutput("basic_res", 256'(out_res), 256'({32'hB, 32'hA}));
        checkOutput("basic_we", 256'(out_we), 256'd3);
        applyStimulus(1'b0, 2'b11, 10'd0, 64'd0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_valid", 256'(out_valid), 256'd0);
        checkOutput("drain_we_masked", 256'(out_we), 256'd0);

        // Stall: A goes to main, B to skid, C is refused until skid drains
        applyStimulus(1'b1, 2'b11, RD_A, RES_A, 1'b0, 1'b0);
        tick();
        checkOutput("stall_a_ready", 256'(in_ready), 256'd1);
        applyStimulus(1'b1, 2'b11, RD_B, RES_B, 1'b0, 1'b0);
        tick();
        checkOutput("stall_b_ready", 256'(in_ready), 256'd0);
        checkOutput("stall_main_a", 256'(out_res), 256'(RES_A));
        applyStimulus(1'b1, 2'b11, RD_C, RES_C, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("stall_c_refused_res", 256'(out_res), 256'(RES_A));
        checkOutput("stall_c_refused_ready", 256'(in_ready), 256'd0);
        applyStimulus(1'b1, 2'b11, RD_C, RES_C, 1'b1, 1'b0);
        tick();
        checkOutput("order_b_res", 256'(out_res), 256'(RES_B));
        checkOutput("order_b_rd", 256'(out_rd), 256'(RD_B));
        checkOutput("order_b_ready", 256'(in_ready), 256'd1);
        tick();
        checkOutput("order_c_res", 256'(out_res), 256'(RES_C));
        checkOutput("order_c_valid", 256'(out_valid), 256'd1);
        applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, 1'b1, 1'b0);
        tick();
        checkOutput("order_empty", 256'(out_valid), 256'd0);

        // Write-enable cleanup: duplicate rd and writes to r0
        applyStimulus(1'b1, 2'b11, {5'd5, 5'd5}, RES_A, 1'b1, 1'b0);
        tick();
        checkOutput("dup_rd_we", 256'(out_we), 256'b10);
        applyStimulus(1'b1, 2'b11, {5'd0, 5'd9}, RES_B, 1'b1, 1'b0);
        tick();
        checkOutput("r0_we", 256'(out_we), 256'b01);
        applyStimulus(1'b1, 2'b01, {5'd4, 5'd4}, RES_C, 1'b1, 1'b0);
        tick();
        checkOutput("dup_rd_upper_off_we", 256'(out_we), 256'b01);
        applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, 1'b1, 1'b0);
        tick();

        // Flush with both slots full and a beat arriving
        applyStimulus(1'b1, 2'b11, RD_A, RES_A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b11, RD_B, RES_B, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_ready", 256'(in_ready), 256'd0);
        applyStimulus(1'b1, 2'b11, RD_D, RES_D, 1'b0, 1'b1);
        tick();
        checkOutput("flush_valid", 256'(out_valid), 256'd0);
        checkOutput("flush_ready", 256'(in_ready), 256'd1);
        checkOutput("flush_we", 256'(out_we), 256'd0);
        applyStimulus(1'b0, 2'b11, RD_D, RES_D, 1'b1, 1'b0);
        tick();
        checkOutput("flush_dropped", 256'(out_valid), 256'd0);
        tick();
        checkOutput("flush_dropped2", 256'(out_valid), 256'd0);

        // Streaming: one bundle per cycle and in_ready stays high
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 2'b11, RD_A, {32'(i + 500), 32'(i)}, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream_res_%0d", i), 256'(out_res),
                        256'({32'(i + 500), 32'(i)}));
            checkOutput($sformatf("stream_valid_%0d", i), 256'(out_valid), 256'd1);
            checkOutput($sformatf("stream_ready_%0d", i), 256'(in_ready), 256'd1);
        end
        applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_end_valid", 256'(out_valid), 256'd0);

        // Reset in the middle of a stall discards both held bundles
        applyStimulus(1'b1, 2'b11, RD_A, RES_A, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 2'b11, RD_B, RES_B, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        checkOutput("midrst_valid", 256'(out_valid), 256'd0);
        checkOutput("midrst_ready", 256'(in_ready), 256'd1);
        checkOutput("midrst_res", 256'(out_res), 256'd0);
        tick();
        reset = 1'b0;
        applyStimulus(1'b1, 2'b11, RD_C, RES_C, 1'b1, 1'b0);
        tick();
        checkOutput("post_rst_res", 256'(out_res), 256'(RES_C));
        checkOutput("post_rst_valid", 256'(out_valid), 256'd1);
        applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, 1'b1, 1'b0);
        tick();

        // Four-lane build: lanes 3..0 write rd 2,2,2,1
        in_valid4 = 1'b1;
        in_we4    = 4'b1111;
        in_rd4    = {5'd2, 5'd2, 5'd2, 5'd1};
        in_res4   = {64'd13, 64'd12, 64'd11, 64'd10};
        tick();
        in_valid4 = 1'b0;
        checkOutput("lanes4_we", 256'(out_we4), 256'b1001);
        checkOutput("lanes4_valid", 256'(out_valid4), 256'd1);
        checkOutput("lanes4_res", out_res4, {64'd13, 64'd12, 64'd11, 64'd10});
        tick();
        checkOutput("lanes4_empty_we", 256'(out_we4), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
